branch_comparator: RTL and testbench
====================================

Name: branch_comparator

Overview:
- 32-bit magnitude/equality comparator for the stage-2 branch-resolution path.
- Compares two register-file read operands (rs1d, rs2d) and produces equal and less-than flags.
- Less-than is signed or unsigned, selected by s; the flags drive BEQ/BNE/BLT/BGE/BLTU/BGEU decisions.
- Flags are registered: one clock of latency, synchronous active-low reset.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of SLICE.
- SLICE, 8, bit width of each comparison slice in the reduction tree.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active low.
- rs1d  input  WIDTH  first operand (rs1 read data).
- rs2d  input  WIDTH  second operand (rs2 read data).
- s  input  1  1 = signed two's-complement compare; 0 = unsigned compare.
- eq  output  1  registered: 1 when rs1d == rs2d.
- lt  output  1  registered: 1 when rs1d < rs2d under the mode selected by s.

Behaviour:
- Reset: on a rising clk edge with rst_n = 0, eq and lt are set to 0. Reset has priority over the operands.
- Normal operation: on each rising clk edge with rst_n = 1, eq and lt capture the comparison of rs1d, rs2d and s as sampled at that edge.
  - Latency is exactly 1 cycle.
  - There is no valid or enable handshake; the block evaluates every cycle.
  - Outputs are stable for the full cycle after the edge.
- eq is set to 1 exactly when all WIDTH bits match. eq does not depend on s.
- lt, unsigned mode (s = 0): lt = 1 when rs1d < rs2d as unsigned integers.
- lt, signed mode (s = 1): lt = 1 when rs1d < rs2d as two's-complement integers.
  - If the MSBs differ, lt = rs1d[MSB]; the negative operand is the smaller one.
  - If the MSBs are equal, the result is the unsigned compare of the full words.
- eq and lt are never both 1. When eq = 1, lt = 0.
- Boundary cases, all required:
  - 0x80000000 vs 0x7FFFFFFF: signed lt = 1, unsigned lt = 0.
  - 0xFFFFFFFF vs 0x00000000: signed lt = 1, unsigned lt = 0.
  - Identical operands: eq = 1 and lt = 0 in both modes.
- Reset mid-operation: deasserting rst_n resumes comparison on the next edge. No other state exists.
- Structure: the operands are split into WIDTH/SLICE slices.
  - Each slice produces unsigned slice_eq and slice_lt.
  - A combinational reduction tree merges slices from MSB to LSB: lt = hi_lt | (hi_eq & lo_lt); eq = hi_eq & lo_eq.
  - The signed correction is applied only at the top slice by inverting the MSB compare sense.
- No X propagation from unused logic; outputs are fully defined after the first reset edge.

Decomposition:
- Shared package (stage2_pkg): WIDTH default and the compare-mode encodings (CMP_UNSIGNED = 0, CMP_SIGNED = 1).
- Sub-module cmp_slice: a SLICE-bit unsigned compare producing slice_eq and slice_lt.
  - It is instantiated WIDTH/SLICE times via generate.
  - The top level holds the merge tree, the signed fix-up and the output registers.

Test Plan:
- Reset: hold rst_n = 0 with rs1d = rs2d = 0x00000005 → after the edge, eq = 0 and lt = 0. Release rst_n → next edge gives eq = 1, lt = 0.
- Equality: rs1d = rs2d = 0xDEADBEEF with s = 0, then s = 1 → eq = 1, lt = 0 both times. Then rs1d = 0xDEADBEEE, rs2d = 0xDEADBEEF, s = 0 → eq = 0, lt = 1.
- Sign boundary:
  - rs1d = 0x80000000, rs2d = 0x7FFFFFFF, s = 1 → lt = 1; same operands with s = 0 → lt = 0.
  - Swapped operands (rs1d = 0x7FFFFFFF, rs2d = 0x80000000), s = 1 → lt = 0.
- All-ones vs zero: rs1d = 0xFFFFFFFF, rs2d = 0x00000000 → s = 1 gives lt = 1; s = 0 gives lt = 0. Both eq = 0.
- Slice boundaries: rs1d = 0x00010000, rs2d = 0x0000FFFF, s = 0 → lt = 0. rs1d = 0x12340000, rs2d = 0x12340001 → lt = 1.
- Latency and random checks: change the operands every cycle → each result appears exactly one edge later. Then 100 random vectors in both modes, checked against a behavioural signed/unsigned model.

Source files
------------

// File: rtl/branch_comparator_pkg.sv
// Shared stage-2 definitions: default comparator geometry and compare-mode encodings.
package stage2_pkg;

  localparam int CMP_WIDTH = 32;
  localparam int CMP_SLICE = 8;

  typedef enum logic {
    CMP_UNSIGNED = 1'b0,
    CMP_SIGNED   = 1'b1
  } cmp_mode_e;

  typedef struct packed {
    logic eq;
    logic lt;
  } cmp_flags_t;

  // Combine a more-significant result with the next less-significant one.
  function automatic cmp_flags_t cmpMerge(input cmp_flags_t hi, input cmp_flags_t lo);
    cmp_flags_t res;
    res.lt = hi.lt | (hi.eq & lo.lt);
    res.eq = hi.eq & lo.eq;
    return res;
  endfunction

endpackage

// File: rtl/branch_comparator_cmp_slice.sv
// Unsigned equality / less-than compare of one operand slice.
module cmp_slice
  import stage2_pkg::*;
#(
  parameter int W = CMP_SLICE
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_slice_eq,
  output logic         o_slice_lt
);

  assign o_slice_eq = (i_a == i_b);
  assign o_slice_lt = (i_a < i_b);

endmodule

// File: rtl/branch_comparator.sv
// Registered signed/unsigned branch comparator built from per-slice compares and an MSB-first merge.
module branch_comparator
  import stage2_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH,
  parameter int SLICE = CMP_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rs1d,
  input  logic [WIDTH-1:0] rs2d,
  input  logic             s,
  output logic             eq,
  output logic             lt
);

  localparam int NSLICE = WIDTH / SLICE;

  logic             w_signFlip;
  logic [WIDTH-1:0] w_opA;
  logic [WIDTH-1:0] w_opB;
  logic [NSLICE-1:0] w_sliceEq;
  logic [NSLICE-1:0] w_sliceLt;
  cmp_flags_t       w_result;
  logic             r_eq;
  logic             r_lt;

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  assign w_signFlip = (s == CMP_SIGNED);
  assign w_opA = {rs1d[WIDTH-1] ^ w_signFlip, rs1d[WIDTH-2:0]};
  assign w_opB = {rs2d[WIDTH-1] ^ w_signFlip, rs2d[WIDTH-2:0]};

  for (genvar g = 0; g < NSLICE; g++) begin : g_slice
    cmp_slice #(
      .W(SLICE)
    ) u_slice (
      .i_a        (w_opA[g*SLICE +: SLICE]),
      .i_b        (w_opB[g*SLICE +: SLICE]),
      .o_slice_eq (w_sliceEq[g]),
      .o_slice_lt (w_sliceLt[g])
    );
  end

  always_comb begin
    cmp_flags_t lo;
    w_result.eq = 1'b1;
    w_result.lt = 1'b0;
    for (int i = NSLICE - 1; i >= 0; i--) begin
      lo.eq = w_sliceEq[i];
      lo.lt = w_sliceLt[i];
      w_result = cmpMerge(w_result, lo);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_eq <= 1'b0;
      r_lt <= 1'b0;
    end else begin
      r_eq <= w_result.eq;
      r_lt <= w_result.lt;
    end
  end

  assign eq = r_eq;
  assign lt = r_lt;

endmodule

// File: tb/tb_branch_comparator.sv
// Directed and random checks of the registered branch comparator.
module tb_branch_comparator;

  logic        clk;
  logic        rst_n;
  logic [31:0] rs1d;
  logic [31:0] rs2d;
  logic        s;
  logic        eq;
  logic        lt;

  int checks = 0;
  int errors = 0;

  branch_comparator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rs1d  (rs1d),
    .rs2d  (rs2d),
    .s     (s),
    .eq    (eq),
    .lt    (lt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit modelLt(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    if (sgn) return ($signed(a) < $signed(b));
    return (a < b);
  endfunction

  // Drive new inputs away from the active edge, then let one edge capture them.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic mode);
    @(negedge clk);
    rs1d = a;
    rs2d = b;
    s    = mode;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic expEq, input logic expLt);
    checks++;
    assert (eq === expEq) else begin
      errors++;
      $error("[TB] FAIL %s eq: got %b expected %b", tag, eq, expEq);
    end
    checks++;
    assert (lt === expLt) else begin
      errors++;
      $error("[TB] FAIL %s lt: got %b expected %b", tag, lt, expLt);
    end
  endtask

  logic [31:0] va [6];
  logic [31:0] vb [6];
  logic        vs [6];

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    bit          m;
    bit          expEq;
    bit          expLt;

    rst_n = 1'b0;
    rs1d  = 32'h0000_0005;
    rs2d  = 32'h0000_0005;
    s     = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_hold", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_release", 1'b1, 1'b0);

    applyStimulus(32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    checkOutput("equal_unsigned", 1'b1, 1'b0);
    applyStimulus(32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
    checkOutput("equal_signed", 1'b1, 1'b0);
    applyStimulus(32'hDEADBEEE, 32'hDEADBEEF, 1'b0);
    checkOutput("lsb_less", 1'b0, 1'b1);

    applyStimulus(32'h80000000, 32'h7FFFFFFF, 1'b1);
    checkOutput("minint_vs_maxint_signed", 1'b0, 1'b1);
    applyStimulus(32'h80000000, 32'h7FFFFFFF, 1'b0);
    checkOutput("minint_vs_maxint_unsigned", 1'b0, 1'b0);
    applyStimulus(32'h7FFFFFFF, 32'h80000000, 1'b1);
    checkOutput("maxint_vs_minint_signed", 1'b0, 1'b0);
    applyStimulus(32'h7FFFFFFF, 32'h80000000, 1'b0);
    checkOutput("maxint_vs_minint_unsigned", 1'b0, 1'b1);

    applyStimulus(32'hFFFFFFFF, 32'h00000000, 1'b1);
    checkOutput("ones_vs_zero_signed", 1'b0, 1'b1);
    applyStimulus(32'hFFFFFFFF, 32'h00000000, 1'b0);
    checkOutput("ones_vs_zero_unsigned", 1'b0, 1'b0);
    applyStimulus(32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1);
    checkOutput("neg_two_vs_neg_one_signed", 1'b0, 1'b1);

    applyStimulus(32'h00010000, 32'h0000FFFF, 1'b0);
    checkOutput("slice_carry_boundary", 1'b0, 1'b0);
    applyStimulus(32'h12340000, 32'h12340001, 1'b0);
    checkOutput("low_slice_decides", 1'b0, 1'b1);
    applyStimulus(32'h12FF0000, 32'h13000000, 1'b1);
    checkOutput("top_slice_decides", 1'b0, 1'b1);

    // Reset in the middle of traffic clears the flags, then comparison resumes.
    @(negedge clk);
    rst_n = 1'b0;
    rs1d  = 32'h00000001;
    rs2d  = 32'h00000002;
    s     = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_reset", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("after_mid_reset", 1'b0, 1'b1);

    // Back-to-back vectors: outputs must hold until the edge, then show the new result.
    va[0] = 32'h00000003; vb[0] = 32'h00000003; vs[0] = 1'b0;
    va[1] = 32'h80000000; vb[1] = 32'h00000001; vs[1] = 1'b1;
    va[2] = 32'h80000000; vb[2] = 32'h00000001; vs[2] = 1'b0;
    va[3] = 32'h00000010; vb[3] = 32'h00000020; vs[3] = 1'b0;
    va[4] = 32'hFFFF0000; vb[4] = 32'hFFFF0000; vs[4] = 1'b1;
    va[5] = 32'h00000020; vb[5] = 32'h00000010; vs[5] = 1'b1;
    expEq = 1'b0;
    expLt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rs1d = va[i];
      rs2d = vb[i];
      s    = vs[i];
      #1;
      checkOutput($sformatf("latency_hold_%0d", i), expEq, expLt);
      expEq = (va[i] == vb[i]);
      expLt = modelLt(va[i], vb[i], vs[i]);
      @(posedge clk);
      #1;
      checkOutput($sformatf("latency_new_%0d", i), expEq, expLt);
    end

    for (int i = 0; i < 100; i++) begin
      a = $urandom;
      case (i % 4)
        0:       b = a;
        1:       b = a ^ (32'h1 << $urandom_range(31, 0));
        2:       b = {a[31:8], 8'($urandom)};
        default: b = $urandom;
      endcase
      for (int k = 0; k < 2; k++) begin
        m = (k == 1);
        applyStimulus(a, b, m);
        checkOutput($sformatf("random_%0d_s%0d_%08h_%08h", i, k, a, b), (a == b), modelLt(a, b, m));
      end
    end

    $display("[TB] done");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
